dcache_req_buffer: RTL

- Elastic request buffer between the compute-unit pipeline's L1 data-cache request port and the L1 data cache.
- Decouples pipeline back-pressure from cache stalls with a DEPTH-entry FIFO.
- Caps in-flight reads at MAX_OUTSTANDING by counting read issues against returned responses.
- Response channel is a combinational passthrough from cache to pipeline, observed only for credit return.

---
 rtl/dcache_req_buffer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dcache_req_buffer.sv
// Elastic request FIFO between the pipeline L1 D-cache port and the L1 data cache.
// In-flight reads are capped by a credit counter. DCACHE_REQ_BUFFER_PERF_EN adds stall counters.

module dcache_req_buffer_checker #(
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             reset,
    input logic             rsp_fire,
    input logic [CNT_W-1:0] outstanding
);
    // The cache must never return a response when no read is in flight.
    assert property (@(posedge clk) disable iff (reset) rsp_fire |-> (outstanding != '0));
endmodule

module dcache_req_buffer #(
    parameter int NUM_LANES       = 4,
    parameter int ADDR_WIDTH      = 30,
    parameter int DATA_WIDTH      = 32,
    parameter int TAG_WIDTH       = 8,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_LANES-1:0]                in_valid,
    input  logic                                in_rw,
    input  logic [NUM_LANES*DATA_WIDTH/8-1:0]   in_byteen,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0]     in_addr,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]     in_data,
    input  logic [TAG_WIDTH-1:0]                in_tag,
    output logic                                in_ready,
    output logic [NUM_LANES-1:0]                out_valid,
    output logic                                out_rw,
    output logic [NUM_LANES*DATA_WIDTH/8-1:0]   out_byteen,
    output logic [NUM_LANES*ADDR_WIDTH-1:0]     out_addr,
    output logic [NUM_LANES*DATA_WIDTH-1:0]     out_data,
    output logic [TAG_WIDTH-1:0]                out_tag,
    input  logic                                out_ready,
    input  logic [NUM_LANES-1:0]                rsp_in_valid,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]     rsp_in_data,
    input  logic [TAG_WIDTH-1:0]                rsp_in_tag,
    output logic                                rsp_in_ready,
    output logic [NUM_LANES-1:0]                rsp_out_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0]     rsp_out_data,
    output logic [TAG_WIDTH-1:0]                rsp_out_tag,
    input  logic                                rsp_out_ready,
    output logic [$clog2(DEPTH):0]              occupancy,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding
`ifdef DCACHE_REQ_BUFFER_PERF_EN
    ,
    output logic [31:0]                         perf_stall_full,
    output logic [31:0]                         perf_stall_credit
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int BE_W  = NUM_LANES * DATA_WIDTH / 8;
    localparam logic [OCC_W-1:0] FULL_C  = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_LANES-1:0]            mask_mem_r   [DEPTH];
    logic                            rw_mem_r     [DEPTH];
    logic [BE_W-1:0]                 byteen_mem_r [DEPTH];
    logic [NUM_LANES*ADDR_WIDTH-1:0] addr_mem_r   [DEPTH];
    logic [NUM_LANES*DATA_WIDTH-1:0] data_mem_r   [DEPTH];
    logic [TAG_WIDTH-1:0]            tag_mem_r    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occupancy_r;
    logic [CNT_W-1:0] outstanding_r;

    logic                 in_ready_s;
    logic                 in_fire_s;
    logic                 head_blocked_s;
    logic [NUM_LANES-1:0] out_valid_s;
    logic                 out_fire_s;
    logic                 rd_issue_s;
    logic                 rsp_fire_s;

    // Handshakes and the credit stall: a head read waits in place, so younger writes wait too.
    always_comb begin
        in_ready_s     = !reset && (occupancy_r != FULL_C);
        in_fire_s      = (|in_valid) && in_ready_s;
        head_blocked_s = !rw_mem_r[rd_ptr_r] && (outstanding_r == MAX_C);
        if ((occupancy_r != '0) && !head_blocked_s) begin
            out_valid_s = mask_mem_r[rd_ptr_r];
        end else begin
            out_valid_s = '0;
        end
        out_fire_s = (|out_valid_s) && out_ready;
        rd_issue_s = out_fire_s && !rw_mem_r[rd_ptr_r];
        rsp_fire_s = (|rsp_in_valid) && rsp_out_ready;
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_s;
    assign out_rw      = rw_mem_r[rd_ptr_r];
    assign out_byteen  = byteen_mem_r[rd_ptr_r];
    assign out_addr    = addr_mem_r[rd_ptr_r];
    assign out_data    = data_mem_r[rd_ptr_r];
    assign out_tag     = tag_mem_r[rd_ptr_r];
    assign occupancy   = occupancy_r;
    assign outstanding = outstanding_r;

    assign rsp_in_ready  = rsp_out_ready;
    assign rsp_out_valid = rsp_in_valid;
    assign rsp_out_data  = rsp_in_data;
    assign rsp_out_tag   = rsp_in_tag;

    // Entry storage; contents are qualified by occupancy so they need no reset.
    always_ff @(posedge clk) begin
        if (in_fire_s) begin
            mask_mem_r[wr_ptr_r]   <= in_valid;
            rw_mem_r[wr_ptr_r]     <= in_rw;
            byteen_mem_r[wr_ptr_r] <= in_byteen;
            addr_mem_r[wr_ptr_r]   <= in_addr;
            data_mem_r[wr_ptr_r]   <= in_data;
            tag_mem_r[wr_ptr_r]    <= in_tag;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            occupancy_r <= '0;
        end else begin
            if (in_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (out_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({in_fire_s, out_fire_s})
                2'b10:   occupancy_r <= occupancy_r + OCC_ONE;
                2'b01:   occupancy_r <= occupancy_r - OCC_ONE;
                default: occupancy_r <= occupancy_r;
            endcase
        end
    end

    // Read credits: issued reads count up, responses count down, never below zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_r <= '0;
        end else begin
            case ({rd_issue_s, rsp_fire_s})
                2'b10: outstanding_r <= outstanding_r + CNT_ONE;
                2'b01: begin
                    if (outstanding_r != '0) begin
                        outstanding_r <= outstanding_r - CNT_ONE;
                    end else begin
                        outstanding_r <= outstanding_r;
                    end
                end
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    dcache_req_buffer_checker #(.CNT_W(CNT_W)) u_checker (
        .clk         (clk),
        .reset       (reset),
        .rsp_fire    (rsp_fire_s),
        .outstanding (outstanding_r)
    );

`ifdef DCACHE_REQ_BUFFER_PERF_EN
    logic [31:0] perf_full_r;
    logic [31:0] perf_credit_r;

    // Stall counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_full_r   <= 32'd0;
            perf_credit_r <= 32'd0;
        end else begin
            if ((|in_valid) && !in_ready_s) begin
                perf_full_r <= perf_full_r + 32'd1;
            end
            if ((occupancy_r != '0) && head_blocked_s) begin
                perf_credit_r <= perf_credit_r + 32'd1;
            end
        end
    end

    assign perf_stall_full   = perf_full_r;
    assign perf_stall_credit = perf_credit_r;
`endif
endmodule
